// File: rtl/spi_pkg.sv
// Shared command codes, FSM state type and frame header width for the SPI master.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_HDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    CAPTURE,
    FINISH
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: shifts toward the MSB, new bits enter at the LSB.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one request per frame, MSB-first serialisation on MOSI, MISO capture for read-data.
// Handshake: a request is taken when req_valid && req_ready at a rising edge; req_ready is high only in IDLE.
module spi_master_ctrl import spi_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  input  logic [1:0]                    req_cmd,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          SS_n,
  output logic                          MOSI,
  input  logic                          MISO,
  output state_t                        dbg_state,
  output logic [FRAME_HDR_W+DATA_W-1:0] dbg_tx
);

  localparam int FRAME_W = FRAME_HDR_W + DATA_W;
  localparam int CNT_MAX = (READ_LAT > FRAME_W) ? READ_LAT : FRAME_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (READ_LAT < 0 || READ_LAT > 15) begin : g_bad_read_lat
    $error("spi_master_ctrl: READ_LAT must be in 0..15");
  end

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          cmd_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [FRAME_W-1:0]  tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                accept;

  assign accept = req_valid && (state == IDLE);

  // The first frame bit is the slave's read/write select, so cmd[1] leads twice.
  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ({req_cmd[1], req_cmd, req_data}),
    .shift_en (state == SHIFT),
    .sin      (1'b0),
    .q        (tx_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (state == CAPTURE),
    .sin      (MISO),
    .q        (rx_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = START;
      START:   state_nx = SHIFT;
      SHIFT:   if (cnt == '0) begin
                 if (cmd_q == CMD_RD_DATA) state_nx = (READ_LAT > 0) ? WAIT : CAPTURE;
                 else                      state_nx = FINISH;
               end
      WAIT:    if (cnt == '0) state_nx = CAPTURE;
      CAPTURE: if (cnt == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE:                 req_ready = 1'b1;
      START, WAIT, CAPTURE: SS_n = 1'b0;
      SHIFT:   begin
                 SS_n = 1'b0;
                 MOSI = tx_q[FRAME_W-1];
               end
      FINISH:               rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Counter is loaded with (cycles-1) on entry to each timed state, then counts down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != state_nx) begin
      unique case (state_nx)
        SHIFT:   cnt <= CNT_W'(FRAME_W - 1);
        WAIT:    cnt <= CNT_W'(READ_LAT - 1);
        CAPTURE: cnt <= CNT_W'(DATA_W - 1);
        default: cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) cmd_q <= req_cmd;
      if (state == FINISH && cmd_q == CMD_RD_DATA) rdata_q <= rx_q;
    end
  end

  // During a read-data FINISH the fresh capture is presented directly; otherwise the held byte.
  assign rsp_rdata = (state == FINISH && cmd_q == CMD_RD_DATA) ? rx_q : rdata_q;

  assign dbg_state = state;
  assign dbg_tx    = tx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed + randomized bench for spi_master_ctrl with a behavioural slave/RAM model.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [1:0]    req_cmd;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  state_t        dbg_state;
  logic [10:0]   dbg_tx;

  int checks = 0;
  int errors = 0;

  // Slave/RAM reference model
  logic [7:0] mem [256];
  logic [7:0] waddr;
  logic [7:0] raddr;
  logic [7:0] exp_rdata;

  spi_master_ctrl #(.DATA_W(DW), .READ_LAT(RL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .dbg_state (dbg_state),
    .dbg_tx    (dbg_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 into an IDLE cycle; returns at #1 into the following IDLE cycle.
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] data, input int abort_at);
    logic [10:0] frame;
    logic [7:0]  rbyte;
    int          len;
    int          cap0;
    frame = {cmd[1], cmd, data};
    len   = (cmd == 2'b11) ? 20 + RL : 12;
    cap0  = 13 + RL;
    rbyte = mem[raddr];
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    @(posedge clk); #1;
    for (int c = 1; c <= len; c++) begin
      if (c == abort_at) begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        exp_rdata = 8'h00;
        check("abort_ss_n", SS_n, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rdata", rsp_rdata, exp_rdata);
        check("abort_ready", req_ready, 1);
        repeat (2) begin
          @(posedge clk); #1;
          check("abort_hold_rsp_valid", rsp_valid, 0);
          check("abort_hold_ss_n", SS_n, 1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_after_rsp_valid", rsp_valid, 0);
        return;
      end
      if (cmd == 2'b11 && c >= cap0 && c <= cap0 + 7) MISO = rbyte[7 - (c - cap0)];
      else MISO = 1'bx;
      check($sformatf("ss_n_low c%0d", c), SS_n, 0);
      check($sformatf("ready_busy c%0d", c), req_ready, 0);
      check($sformatf("rsp_valid_busy c%0d", c), rsp_valid, 0);
      check($sformatf("rdata_stable c%0d", c), rsp_rdata, exp_rdata);
      check($sformatf("mosi cmd%0d c%0d", cmd, c), MOSI, (c >= 2 && c <= 12) ? frame[12 - c] : 1'b0);
      // Requests while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_cmd   = 2'($urandom);
      req_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    MISO      = 1'bx;
    case (cmd)
      2'b00: waddr = data;
      2'b01: mem[waddr] = data;
      2'b10: raddr = data;
      default: exp_rdata = rbyte;
    endcase
    check("finish_ss_n", SS_n, 1);
    check("finish_rsp_valid", rsp_valid, 1);
    check("finish_ready", req_ready, 0);
    check("finish_mosi", MOSI, 0);
    check($sformatf("finish_rdata cmd%0d", cmd), rsp_rdata, exp_rdata);
    @(posedge clk); #1;
    check("idle_ss_n", SS_n, 1);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
    check("idle_mosi", MOSI, 0);
    check("idle_rdata", rsp_rdata, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    waddr     = 8'h00;
    raddr     = 8'h00;
    exp_rdata = 8'h00;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 2'b00;
    req_data  = 8'h00;
    MISO      = 1'bx;

    // Reset state with MISO undriven
    #12;
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_rdata_x_miso", rsp_rdata, 0);
      check("post_rst_ss_n", SS_n, 1);
      check("post_rst_rsp_valid", rsp_valid, 0);
    end

    // Directed: write address, write data, read back
    run_frame(2'b00, 8'h0F, 0);
    run_frame(2'b01, 8'hC2, 0);
    run_frame(2'b10, 8'h0F, 0);
    run_frame(2'b11, 8'hA5, 0);

    // Back-to-back: each call starts in the IDLE cycle right after FINISH
    run_frame(2'b00, 8'h33, 0);
    run_frame(2'b01, 8'h5A, 0);
    run_frame(2'b11, 8'h00, 0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      run_frame(2'($urandom), 8'($urandom_range(0, 15)), 0);
    end

    // Reset at the 5th SHIFT bit of a read-data frame, then recover
    run_frame(2'b10, 8'h0F, 0);
    run_frame(2'b11, 8'hFF, 6);
    run_frame(2'b01, 8'h96, 0);
    run_frame(2'b10, 8'h0F, 0);
    run_frame(2'b11, 8'h3C, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-clock SPI master that drives the SPI_Wrapper slave/RAM subsystem from a parallel request interface. It sits directly upstream of SPI_Wrapper and owns SS_n and MOSI. It accepts one command/payload pair per frame, serialises it MSB-first, and for read-data frames captures the 8 returned MISO bits. SCK is the shared system clock `clk`; the master launches MOSI on rising edges, and the slave samples on the following rising edge.

Parameters:
DATA_W, 8, payload width (address or data byte); frame length derives from it.
READ_LAT, 2, idle cycles between the last MOSI bit of a read-data frame and the first valid MISO bit (range 0..15).

Ports:
clk  input  1  system clock; also serves as SPI SCK.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_cmd  input  2  00 = write address, 01 = write data, 10 = read address, 11 = read data.
req_data  input  DATA_W  address, write data, or dummy byte (11).
req_ready  output  1  master idle; a request is accepted when req_valid && req_ready at a rising edge.
rsp_valid  output  1  one-cycle pulse at frame end (all commands).
rsp_rdata  output  DATA_W  captured MISO byte; updated only for cmd 11, otherwise held.
SS_n  output  1  slave select, active low.
MOSI  output  1  serial data to slave.
MISO  input  1  serial data from slave.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0, state IDLE, all counters 0.
- Frame bit vector: {cmd[1], cmd[1], cmd[0], data[DATA_W-1:0]}, sent MSB-first. There are 11 bits for DATA_W=8. The first bit is the slave's read/write select.
- States:
  - IDLE: SS_n=1, MOSI=0, req_ready=1. An accept at edge T latches cmd/data and goes to START.
  - START: one cycle, SS_n=0, MOSI=0. The slave uses this cycle to leave idle. Goes to SHIFT.
  - SHIFT: 3+DATA_W cycles, one frame bit per cycle, bit counter counts down. After the last bit: cmd 11 goes to WAIT if READ_LAT>0, else CAPTURE; other commands go to FINISH.
  - WAIT: READ_LAT cycles, SS_n=0, MOSI=0.
  - CAPTURE: DATA_W cycles, SS_n=0, MOSI=0. MISO is shifted into a capture register MSB-first on each rising edge. Goes to FINISH.
  - FINISH: one cycle, SS_n=1, MOSI=0, rsp_valid=1. For cmd 11, rsp_rdata = capture register. Goes to IDLE.
- Latency for DATA_W=8, accept at edge T:
  - SS_n is low in cycles T+1..T+12 for cmd 00/01/10.
  - For cmd 11, SS_n is low in cycles T+1..T+20+READ_LAT.
  - FINISH / rsp_valid falls in the cycle after the last SS_n-low cycle.
  - req_ready is 0 from T+1 through FINISH and returns to 1 in the cycle after FINISH.
- Back-to-back requests: the minimum SS_n-high gap between frames is 2 cycles (FINISH + IDLE accept cycle).
- req_valid while busy: ignored (req_ready=0). req_cmd and req_data are sampled only at accept.
- rsp_rdata is stable between FINISH pulses. It is not cleared on write frames.
- MISO is ignored outside CAPTURE. X on MISO during other states must not propagate to rsp_rdata.
- Reset mid-frame: SS_n returns to 1 immediately (asynchronously). No rsp_valid is generated for the aborted frame, and rsp_rdata returns to 0.
- Counters are sized to hold max(3+DATA_W, DATA_W, READ_LAT) with no wrap. A READ_LAT outside 0..15 is a parameter error and must be caught by an elaboration-time check.

Decomposition:
- Package spi_pkg:
  - cmd localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - state enum {IDLE, START, SHIFT, WAIT, CAPTURE, FINISH}.
  - FRAME_HDR_W=3.
- Sub-module: spi_shift_reg (parallel load, shift-out MSB / shift-in LSB), instantiated once for TX and once for RX.
- The FSM and counters stay in spi_master_ctrl.

Test Plan:
1. Reset with no request: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0. Inject MISO=X: rsp_rdata stays 0.
2. Write address, req_cmd=00, data=0x0F: MOSI after START = 0,0,0,0,0,0,0,1,1,1,1. SS_n is low exactly 12 cycles, then one rsp_valid pulse with SS_n=1.
3. Write data, req_cmd=01, data=0xC2, connected to SPI_Wrapper: MOSI = 0,0,1,1,1,0,0,0,0,1,0, and RAM mem[0x0F]=0xC2 afterwards.
4. Read address 0x0F (cmd 10), then read data (cmd 11, dummy 0xA5) into SPI_Wrapper: rsp_rdata=0xC2 at the second rsp_valid. SS_n is low 20+READ_LAT cycles on the read-data frame.
5. Back-to-back: req_valid held high with 3 queued requests. Each accept is exactly 2 SS_n-high cycles after the previous frame, and req_ready=0 throughout each frame.
6. Assert rst_n=0 at the 5th SHIFT bit of a read-data frame: SS_n=1 asynchronously, no rsp_valid. After release, the next request completes correctly.
